dpram_param: RTL and testbench
==============================

// Module: dpram_param
// PURPOSE
//  Parametrised true dual-port block RAM, successor to the fixed 16x1024 dual-port RAM.
//  Configurable width and depth, optional output pipeline register, selectable read-during-write mode.
//  Adds a hardware clear engine, per-port read-valid strobes and write-collision detection.
//  Sits between the CPU/datapath ports and the memory-mapped I/O ports of the system.
// PARAMETERS
//  DATA_W       16       word width, bits
//  ADDR_W       10       address width; DEPTH = 2**ADDR_W words
//  OUT_REG      0        0: read latency 1; 1: extra output register, latency 2
//  RDW_MODE     0        same-port write returns: 0 = new data (write-first), 1 = old data (read-first)
//  CLEAR_ON_RST 1        1: run clear engine automatically after rst_n deasserts
//  CLEAR_VAL    16'h0000 value written to every word by the clear engine (DATA_W bits)
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  clear_req  in   1       pulse: start a full-array clear (ignored while busy)
//  busy       out  1       1 while the clear engine owns the array
//  collision  out  1       1-cycle pulse: both ports wrote the same address
//  en_A/en_B      in   1       port access request (read, or write if we_X)
//  we_A/we_B      in   1       write enable, qualified by en_X
//  addr_A/addr_B  in   ADDR_W  word address
//  data_A/data_B  in   DATA_W  write data
//  out_A/out_B    out  DATA_W  read data, held until the next valid
//  valid_A/valid_B out 1       out_X updated this cycle
// BEHAVIOUR
//  Reset (async): out_X=0, valid_X=0, collision=0, pipeline flushed, addr counter=0.
//   FSM -> CLEAR if CLEAR_ON_RST else IDLE. busy = (state==CLEAR).
//   Array contents are not reset; they are only zeroed by CLEAR.
//  FSM states: IDLE, CLEAR.
//   IDLE + clear_req -> CLEAR next cycle; counter=0.
//   CLEAR: writes CLEAR_VAL to mem[counter] each cycle; counter++.
//   CLEAR + counter==DEPTH-1 -> IDLE. busy=1 for exactly DEPTH cycles.
//   clear_req during CLEAR: ignored, no restart.
//  Access accepted when en_X && !busy. Accesses during busy are dropped: no write, no valid.
//  Latency: valid_X asserts exactly 1+OUT_REG cycles after an accepted access, reads and writes alike.
//  Read: out_X = mem[addr_X] sampled at the accept edge.
//  Write: mem[addr_X] <= data_X. out_X = data_X if RDW_MODE=0; prior mem contents if RDW_MODE=1.
//  Cross-port, same address, one writes and the other reads: the reader returns OLD data in both modes.
//  Both ports write the same address in the same cycle:
//   - port A data is stored; port B write is discarded;
//   - collision pulses 1+OUT_REG cycles later, aligned with valid;
//   - RDW_MODE=0: out_A = out_B = data_A; RDW_MODE=1: both return old data.
//  Different addresses: fully independent, one access per port per cycle.
//  Reads in flight when CLEAR starts complete normally with pre-clear data.
//  Address wrap: none; addr is exactly ADDR_W bits, so all DEPTH words are reachable.
//  Reset mid-CLEAR: counter restarts from 0 on deassert (if CLEAR_ON_RST). Reset mid-read: valid is lost.
// TESTING
//  1 Reset, CLEAR_ON_RST=1, ADDR_W=4 -> busy high exactly 16 cycles; then read all addrs -> 0x0000.
//  2 Write A addr 5 = 0xBEEF, then read B addr 5 -> out_B=0xBEEF, valid_B 1 cycle after (OUT_REG=0), 2 cycles (OUT_REG=1).
//  3 mem[3]=0x1111; write A addr 3 = 0x2222 -> out_A 0x2222 (RDW_MODE=0) / 0x1111 (RDW_MODE=1).
//  4 Same cycle: write A addr 7 = 0xAAAA, write B addr 7 = 0x5555 -> collision pulse, then read -> 0xAAAA.
//  5 Same cycle: write A addr 9 = 0x1234, read B addr 9 (old 0x0000) -> out_B=0x0000, next read 0x1234.
//  6 clear_req with en_A mid-clear, rst_n low mid-clear -> no valid_A, clear not restarted;
//    after reset outputs 0 and clear reruns from address 0.

Source files
------------

// File: rtl/dpram_param_if.sv
// One access port of the dual-port RAM: request side from the master, read response from the RAM.
interface dpram_param_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] out;
  logic              valid;

  modport master (output en, we, addr, data, input out, valid);
  modport slave  (input en, we, addr, data, output out, valid);
endinterface

// File: rtl/dpram_param.sv
// Parametrised true dual-port RAM with a hardware clear engine, per-port read-valid strobes
// and same-address write-collision detection. Port A wins a same-address write race.
module dpram_param #(
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       ADDR_W       = 10,
  parameter int unsigned       OUT_REG      = 0,
  parameter int unsigned       RDW_MODE     = 0,
  parameter int unsigned       CLEAR_ON_RST = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL    = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          busy,
  output logic          collision,
  dpram_param_if.slave  port_a,
  dpram_param_if.slave  port_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_a, acc_b, wr_a, wr_b, both_wr;
  logic [DATA_W-1:0] rd_a, rd_b;

  logic              v1_a_q, v1_b_q, c1_q;
  logic [DATA_W-1:0] d1_a_q, d1_b_q;

  // Clear engine: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RST != 0) ? StClear : StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear engine: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear engine: outputs
  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StClear: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign acc_a   = port_a.en && !busy;
  assign acc_b   = port_b.en && !busy;
  assign wr_a    = acc_a && port_a.we;
  assign wr_b    = acc_b && port_b.we;
  assign both_wr = wr_a && wr_b && (port_a.addr == port_b.addr);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= CLEAR_VAL;
    end else begin
      if (wr_b && !both_wr) begin
        mem[port_b.addr] <= port_b.data;
      end
      if (wr_a) begin
        mem[port_a.addr] <= port_a.data;
      end
    end
  end

  // Cross-port readers always see the pre-write contents; only the writing port can bypass.
  always_comb begin
    rd_a = mem[port_a.addr];
    rd_b = mem[port_b.addr];
    if (RDW_MODE == 0) begin
      if (wr_a) begin
        rd_a = port_a.data;
      end
      if (wr_b) begin
        rd_b = both_wr ? port_a.data : port_b.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_a_q <= 1'b0;
      v1_b_q <= 1'b0;
      c1_q   <= 1'b0;
      d1_a_q <= '0;
      d1_b_q <= '0;
    end else begin
      v1_a_q <= acc_a;
      v1_b_q <= acc_b;
      c1_q   <= both_wr;
      if (acc_a) begin
        d1_a_q <= rd_a;
      end
      if (acc_b) begin
        d1_b_q <= rd_b;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              v2_a_q, v2_b_q, c2_q;
    logic [DATA_W-1:0] d2_a_q, d2_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2_a_q <= 1'b0;
        v2_b_q <= 1'b0;
        c2_q   <= 1'b0;
        d2_a_q <= '0;
        d2_b_q <= '0;
      end else begin
        v2_a_q <= v1_a_q;
        v2_b_q <= v1_b_q;
        c2_q   <= c1_q;
        if (v1_a_q) begin
          d2_a_q <= d1_a_q;
        end
        if (v1_b_q) begin
          d2_b_q <= d1_b_q;
        end
      end
    end

    assign port_a.valid = v2_a_q;
    assign port_b.valid = v2_b_q;
    assign port_a.out   = d2_a_q;
    assign port_b.out   = d2_b_q;
    assign collision    = c2_q;
  end else begin : g_no_out_reg
    assign port_a.valid = v1_a_q;
    assign port_b.valid = v1_b_q;
    assign port_a.out   = d1_a_q;
    assign port_b.out   = d1_b_q;
    assign collision    = c1_q;
  end

endmodule

// File: tb/tb_dpram_param.sv
// Bench: two RAMs (OUT_REG=0/RDW_MODE=0 and OUT_REG=1/RDW_MODE=1) share stimulus;
// expected responses are queued at issue time and a negedge monitor pops and compares them.
module tb_dpram_param;

  typedef struct packed {
    logic [15:0] data;
    int unsigned due;
    logic        coll;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear_req = 1'b0;
  logic        busy0, busy1, coll0, coll1;
  int unsigned cyc = 0;
  int          checks = 0;
  int          fails = 0;

  // Scoreboard index: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B
  exp_t        sb [4][$];
  logic        mv [4];
  logic [15:0] mo [4];
  logic        mc [4];
  logic [15:0] last [4];

  dpram_param_if #(.DATA_W(16), .ADDR_W(4)) a0 ();
  dpram_param_if #(.DATA_W(16), .ADDR_W(4)) b0 ();
  dpram_param_if #(.DATA_W(16), .ADDR_W(4)) a1 ();
  dpram_param_if #(.DATA_W(16), .ADDR_W(4)) b1 ();

  assign a1.en = a0.en;  assign a1.we = a0.we;  assign a1.addr = a0.addr;  assign a1.data = a0.data;
  assign b1.en = b0.en;  assign b1.we = b0.we;  assign b1.addr = b0.addr;  assign b1.data = b0.data;

  dpram_param #(.DATA_W(16), .ADDR_W(4), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RST(1),
                .CLEAR_VAL(16'h0000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy0), .collision(coll0),
    .port_a(a0), .port_b(b0)
  );

  dpram_param #(.DATA_W(16), .ADDR_W(4), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RST(1),
                .CLEAR_VAL(16'h0000)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy1), .collision(coll1),
    .port_a(a1), .port_b(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mv[0] = a0.valid;  assign mo[0] = a0.out;  assign mc[0] = coll0;
  assign mv[1] = b0.valid;  assign mo[1] = b0.out;  assign mc[1] = coll0;
  assign mv[2] = a1.valid;  assign mo[2] = a1.out;  assign mc[2] = coll1;
  assign mv[3] = b1.valid;  assign mo[3] = b1.out;  assign mc[3] = coll1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        chk($sformatf("reset_valid_p%0d", i), 32'(mv[i]), 32'd0);
        chk($sformatf("reset_out_p%0d", i), 32'(mo[i]), 32'd0);
        chk($sformatf("reset_coll_p%0d", i), 32'(mc[i]), 32'd0);
        last[i] = 16'h0000;
      end else if (mv[i]) begin
        if (sb[i].size() == 0) begin
          chk($sformatf("unexpected_valid_p%0d", i), 32'd1, 32'd0);
        end else begin
          e = sb[i].pop_front();
          chk($sformatf("data_p%0d", i), 32'(mo[i]), 32'(e.data));
          chk($sformatf("latency_p%0d", i), cyc, e.due);
          if (i == 0 || i == 2) begin
            chk($sformatf("collision_p%0d", i), 32'(mc[i]), 32'(e.coll));
          end
        end
        last[i] = mo[i];
      end else begin
        chk($sformatf("hold_p%0d", i), 32'(mo[i]), 32'(last[i]));
        if (i == 0 || i == 2) begin
          chk($sformatf("idle_coll_p%0d", i), 32'(mc[i]), 32'd0);
        end
      end
    end
  end

  task automatic idle_ports();
    a0.en = 1'b0;  a0.we = 1'b0;  a0.addr = '0;  a0.data = '0;
    b0.en = 1'b0;  b0.we = 1'b0;  b0.addr = '0;  b0.data = '0;
  endtask

  // Drives one cycle of accesses; x*0 are expectations for dut0, x*1 for dut1.
  task automatic step(input logic ea, input logic wa, input logic [3:0] aa, input logic [15:0] da,
                      input logic eb, input logic wb, input logic [3:0] ab, input logic [15:0] db,
                      input logic [15:0] xa0, input logic [15:0] xa1,
                      input logic [15:0] xb0, input logic [15:0] xb1, input logic coll);
    a0.en = ea;  a0.we = wa;  a0.addr = aa;  a0.data = da;
    b0.en = eb;  b0.we = wb;  b0.addr = ab;  b0.data = db;
    if (ea) begin
      sb[0].push_back('{data: xa0, due: cyc + 1, coll: coll});
      sb[2].push_back('{data: xa1, due: cyc + 2, coll: coll});
    end
    if (eb) begin
      sb[1].push_back('{data: xb0, due: cyc + 1, coll: 1'b0});
      sb[3].push_back('{data: xb1, due: cyc + 2, coll: 1'b0});
    end
    @(posedge clk);
    #1;
    idle_ports();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 32'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 32'd0);
  endtask

  task automatic count_busy(input string name, input int window);
    int c0, c1;
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < window; k++) begin
      @(negedge clk);
      if (busy0) c0++;
      if (busy1) c1++;
    end
    chk({name, "_busy0"}, 32'(c0), 32'd16);
    chk({name, "_busy1"}, 32'(c1), 32'd16);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    idle_ports();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy0", 32'(busy0), 32'd1);
    chk("reset_busy1", 32'(busy1), 32'd1);
    rst_n = 1'b1;
    count_busy("clear_on_rst", 24);

    // Whole array reads back the clear value on both ports
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'(i), 16'h0, 1'b1, 1'b0, 4'(15 - i), 16'h0,
           16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    end
    drain();

    // Write then cross-port read, back to back
    step(1'b1, 1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b0, 4'd0, 16'h0,
         16'hBEEF, 16'h0000, 16'h0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd5, 16'h0,
         16'h0, 16'h0, 16'hBEEF, 16'hBEEF, 1'b0);
    // Same-port read-during-write: new vs old
    step(1'b1, 1'b1, 4'd3, 16'h1111, 1'b0, 1'b0, 4'd0, 16'h0,
         16'h1111, 16'h0000, 16'h0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 4'd3, 16'h2222, 1'b0, 1'b0, 4'd0, 16'h0,
         16'h2222, 16'h1111, 16'h0, 16'h0, 1'b0);
    // Same-address double write: A wins, collision flagged
    step(1'b1, 1'b1, 4'd7, 16'hAAAA, 1'b1, 1'b1, 4'd7, 16'h5555,
         16'hAAAA, 16'h0000, 16'hAAAA, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 4'd7, 16'h0, 1'b1, 1'b0, 4'd7, 16'h0,
         16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 1'b0);
    // A writes while B reads the same word: B sees old data
    step(1'b1, 1'b1, 4'd9, 16'h1234, 1'b1, 1'b0, 4'd9, 16'h0,
         16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd9, 16'h0,
         16'h0, 16'h0, 16'h1234, 16'h1234, 1'b0);
    // Independent writes to different addresses, then swapped reads
    step(1'b1, 1'b1, 4'd10, 16'h0A0A, 1'b1, 1'b1, 4'd11, 16'h0B0B,
         16'h0A0A, 16'h0000, 16'h0B0B, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 4'd11, 16'h0, 1'b1, 1'b0, 4'd10, 16'h0,
         16'h0B0B, 16'h0B0B, 16'h0A0A, 16'h0A0A, 1'b0);
    drain();

    // Read accepted on the clear_req edge completes with pre-clear data
    clear_req = 1'b1;
    step(1'b1, 1'b0, 4'd5, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0,
         16'hBEEF, 16'hBEEF, 16'h0, 16'h0, 1'b0);
    clear_req = 1'b0;
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 5) begin
        // Dropped accesses and an ignored restart request
        a0.en = 1'b1;  a0.we = 1'b1;  a0.addr = 4'd2;  a0.data = 16'hFFFF;
        b0.en = 1'b1;  b0.addr = 4'd5;
        clear_req = 1'b1;
      end else begin
        idle_ports();
        clear_req = 1'b0;
      end
      @(negedge clk);
      if (busy0) c0++;
      if (busy1) c1++;
      @(posedge clk);
      #1;
    end
    idle_ports();
    clear_req = 1'b0;
    chk("clear_req_busy0", 32'(c0), 32'd16);
    chk("clear_req_busy1", 32'(c1), 32'd16);
    step(1'b1, 1'b0, 4'd2, 16'h0, 1'b1, 1'b0, 4'd3, 16'h0,
         16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 4'd5, 16'h0, 1'b1, 1'b0, 4'd7, 16'h0,
         16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    drain();

    // Reset in the middle of a clear: clear reruns in full afterwards
    step(1'b1, 1'b1, 4'd0, 16'hCAFE, 1'b1, 1'b1, 4'd15, 16'hF00D,
         16'hCAFE, 16'h0000, 16'hF00D, 16'h0000, 1'b0);
    drain();
    clear_req = 1'b1;
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_clear_reset_busy0", 32'(busy0), 32'd1);
    chk("mid_clear_reset_busy1", 32'(busy1), 32'd1);
    rst_n = 1'b1;
    count_busy("rerun", 24);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd15, 16'h0,
         16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
